// File: rtl/audio_pkg.sv
// Shared I2S framing constants and helpers for the audio transmit path.
// Pure definitions: no latency, no flow control.
package audio_pkg;

    localparam int I2S_WORD_BITS  = 16;
    localparam int I2S_FRAME_BITS = 32;
    localparam int I2S_LOAD_BC    = 31;
    localparam int I2S_WS_RISE_BC = 15;

    typedef logic [I2S_FRAME_BITS-1:0] frame_t;

    // WS leads the data by one bit: high from bc 15 through bc 30.
    function automatic logic ws_for_bc(input logic [4:0] bc);
        return (bc >= 5'(I2S_WS_RISE_BC)) && (bc != 5'(I2S_LOAD_BC));
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// 2-entry sample-pair FIFO between the core audio path and the serializer.
// Head is visible combinationally; push is gated internally by ready (count < 2).
module i2s_sample_fifo
    import audio_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  frame_t     push_dat,
    input  logic       pop,
    output frame_t     head_dat,
    output logic [1:0] count,
    output logic       ready
);

    frame_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_push;
    logic   do_pop;

    assign ready    = (count != 2'd2);
    assign do_push  = push & ready;
    assign do_pop   = pop & (count != 2'd0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: divides clk into BCK and serializes buffered stereo pairs MSB first.
// First MSB 2*HALF_DIV clocks after en; s_ready drops while the 2-entry buffer is full.
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int HALF_DIV = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     mute,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [I2S_WORD_BITS-1:0] s_left,
    input  logic [I2S_WORD_BITS-1:0] s_right,
    output logic                     i2s_bck,
    output logic                     i2s_ws,
    output logic                     i2s_din,
    output logic                     frame_strobe,
    output logic                     underflow
);

    logic [7:0] div;
    logic [4:0] bc;
    logic [4:0] bc_next;
    frame_t     shift;
    frame_t     last;
    frame_t     head;
    frame_t     load_dat;
    logic [1:0] fifo_count;
    logic       fifo_empty;
    logic       tc;
    logic       fall;
    logic       load;
    logic       pop;

    i2s_sample_fifo u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (s_valid),
        .push_dat ({s_left, s_right}),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_count),
        .ready    (s_ready)
    );

    assign fifo_empty = (fifo_count == 2'd0);
    assign tc         = en && (div == 8'(HALF_DIV - 1));
    assign fall       = tc && i2s_bck;
    assign load       = fall && (bc == 5'(I2S_LOAD_BC));
    assign bc_next    = bc + 5'd1;
    assign pop        = load && !fifo_empty;
    // On an empty load the previous pair is replayed rather than sending silence.
    assign load_dat   = mute ? '0 : (fifo_empty ? last : head);
    assign i2s_din    = shift[I2S_FRAME_BITS-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div          <= '0;
            bc           <= 5'(I2S_LOAD_BC);
            i2s_bck      <= 1'b0;
            i2s_ws       <= 1'b0;
            shift        <= '0;
            last         <= '0;
            frame_strobe <= 1'b0;
            underflow    <= 1'b0;
        end else if (!en) begin
            // Partial frame is abandoned; FIFO and replay register survive.
            div          <= '0;
            bc           <= 5'(I2S_LOAD_BC);
            i2s_bck      <= 1'b0;
            i2s_ws       <= 1'b0;
            shift        <= '0;
            frame_strobe <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            frame_strobe <= load;
            underflow    <= load && fifo_empty;
            if (tc) begin
                div     <= '0;
                i2s_bck <= ~i2s_bck;
            end else begin
                div <= div + 8'd1;
            end
            if (fall) begin
                bc     <= bc_next;
                i2s_ws <= ws_for_bc(bc_next);
                shift  <= load ? load_dat : {shift[I2S_FRAME_BITS-2:0], 1'b0};
            end
            if (pop)
                last <= head;
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: BCK timing, frame contents, underflow, backpressure, mute, disruption.
module tb_i2s_audio_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        mute;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic        i2s_bck;
    logic        i2s_ws;
    logic        i2s_din;
    logic        frame_strobe;
    logic        underflow;

    int tests = 0;
    int fails = 0;
    int ncyc;
    int nstb;
    int nunf;
    logic [31:0] fr_dat;
    logic [31:0] fr_ws;

    localparam logic [31:0] WS_PATTERN = 32'h0001_FFFE;

    i2s_audio_tx #(.HALF_DIV(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mute         (mute),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .i2s_bck      (i2s_bck),
        .i2s_ws       (i2s_ws),
        .i2s_din      (i2s_din),
        .frame_strobe (frame_strobe),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        ncyc++;
        if (frame_strobe === 1'b1) nstb++;
        if (underflow === 1'b1) nunf++;
    endtask

    task automatic wait_bck(input logic lvl);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (i2s_bck !== lvl && n < 100);
        if (i2s_bck !== lvl) check("bck_timeout", {31'd0, i2s_bck}, {31'd0, lvl});
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    // Records din/ws at each of 32 BCK rises; ends on the next load's negedge.
    task automatic capture_frame();
        ncyc = 0;
        nstb = 0;
        nunf = 0;
        fr_dat = '0;
        fr_ws  = '0;
        for (int i = 0; i < 32; i++) begin
            wait_bck(1'b1);
            fr_dat = {fr_dat[30:0], i2s_din};
            fr_ws  = {fr_ws[30:0], i2s_ws};
            wait_bck(1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mute = 1'b0;
        s_valid = 1'b0; s_left = '0; s_right = '0;
        ncyc = 0; nstb = 0; nunf = 0;
        step();
        check("rst_bck", {31'd0, i2s_bck}, 32'd0);
        check("rst_ws", {31'd0, i2s_ws}, 32'd0);
        check("rst_din", {31'd0, i2s_din}, 32'd0);
        check("rst_strobe", {31'd0, frame_strobe}, 32'd0);
        check("rst_underflow", {31'd0, underflow}, 32'd0);
        check("rst_ready", {31'd0, s_ready}, 32'd1);
        reset = 1'b0;
        step();

        // Timing and serial pattern
        push(16'hA5F0, 16'h0F0F);
        en = 1'b1;
        ncyc = 0;
        wait_bck(1'b1);
        check("bck_first_rise", ncyc, 32'd20);
        wait_bck(1'b0);
        check("bck_first_fall", ncyc, 32'd40);
        check("load1_strobe", {31'd0, frame_strobe}, 32'd1);
        check("load1_underflow", {31'd0, underflow}, 32'd0);
        capture_frame();
        check("frame1_data", fr_dat, 32'hA5F0_0F0F);
        check("frame1_ws", fr_ws, WS_PATTERN);
        check("frame_period", ncyc, 32'd1280);
        check("frame1_strobes", nstb, 32'd1);
        check("frame1_underflows", nunf, 32'd1);

        // Disable at bc = 7 while BCK is high, with one pair retained in the FIFO
        push(16'h1234, 16'h8001);
        for (int i = 0; i < 7; i++) begin
            wait_bck(1'b1);
            wait_bck(1'b0);
        end
        wait_bck(1'b1);
        check("bc7_bck", {31'd0, i2s_bck}, 32'd1);
        check("bc7_din", {31'd0, i2s_din}, 32'd1);
        en = 1'b0;
        step();
        check("dis_bck", {31'd0, i2s_bck}, 32'd0);
        check("dis_din", {31'd0, i2s_din}, 32'd0);
        check("dis_ws", {31'd0, i2s_ws}, 32'd0);
        check("dis_ready", {31'd0, s_ready}, 32'd1);

        // Re-enable: clean frame from retained pair, then replay on underflow
        en = 1'b1;
        ncyc = 0;
        wait_bck(1'b1);
        wait_bck(1'b0);
        check("reen_load_time", ncyc, 32'd40);
        check("reen_strobe", {31'd0, frame_strobe}, 32'd1);
        check("reen_underflow", {31'd0, underflow}, 32'd0);
        capture_frame();
        check("frame_1234", fr_dat, 32'h1234_8001);
        check("frame_1234_unf", nunf, 32'd1);
        capture_frame();
        check("frame_replay", fr_dat, 32'h1234_8001);
        check("frame_replay_unf", nunf, 32'd1);
        check("frame_replay_stb", nstb, 32'd1);

        // Backpressure and ordering
        en = 1'b0;
        step();
        s_valid = 1'b1; s_left = 16'h1111; s_right = 16'h2222;
        step();
        s_left = 16'h3333; s_right = 16'h4444;
        step();
        check("bp_full_ready", {31'd0, s_ready}, 32'd0);
        s_left = 16'h5555; s_right = 16'h6666;
        step();
        step();
        check("bp_hold_ready", {31'd0, s_ready}, 32'd0);
        en = 1'b1;
        wait_bck(1'b1);
        wait_bck(1'b0);
        check("bp_load_strobe", {31'd0, frame_strobe}, 32'd1);
        check("bp_ready_after_load", {31'd0, s_ready}, 32'd1);
        step();
        s_valid = 1'b0;
        check("bp_refill_ready", {31'd0, s_ready}, 32'd0);
        capture_frame();
        check("bp_frame0", fr_dat, 32'h1111_2222);
        check("bp_frame0_unf", nunf, 32'd0);
        capture_frame();
        check("bp_frame1", fr_dat, 32'h3333_4444);
        check("bp_frame1_unf", nunf, 32'd0);
        capture_frame();
        check("bp_frame2", fr_dat, 32'h5555_6666);
        check("bp_frame2_unf", nunf, 32'd1);

        // Mute consumes a sample but sends zeros
        en = 1'b0;
        step();
        push(16'h7FFF, 16'h7FFF);
        push(16'h7FFF, 16'h7FFF);
        check("mute_full_ready", {31'd0, s_ready}, 32'd0);
        mute = 1'b1;
        en = 1'b1;
        wait_bck(1'b1);
        wait_bck(1'b0);
        check("mute_strobe", {31'd0, frame_strobe}, 32'd1);
        check("mute_pop_ready", {31'd0, s_ready}, 32'd1);
        mute = 1'b0;
        capture_frame();
        check("mute_frame", fr_dat, 32'h0000_0000);
        check("mute_frame_unf", nunf, 32'd0);
        capture_frame();
        check("post_mute_frame", fr_dat, 32'h7FFF_7FFF);
        check("post_mute_unf", nunf, 32'd1);

        // Asynchronous reset mid-frame discards buffered pairs
        push(16'hAAAA, 16'h5555);
        push(16'h1357, 16'h2468);
        check("pre_rst_ready", {31'd0, s_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            wait_bck(1'b1);
            wait_bck(1'b0);
        end
        wait_bck(1'b1);
        check("pre_rst_bck", {31'd0, i2s_bck}, 32'd1);
        check("pre_rst_din", {31'd0, i2s_din}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_bck", {31'd0, i2s_bck}, 32'd0);
        check("arst_din", {31'd0, i2s_din}, 32'd0);
        check("arst_ws", {31'd0, i2s_ws}, 32'd0);
        check("arst_ready", {31'd0, s_ready}, 32'd1);
        step();
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
